dispatch_sequencer: RTL and testbench

//   Command-driven controller for the 4x4 skewed matrix dispatcher. Accepts a tile command
//   and issues one operand-load strobe per tile. Steps the dispatcher count through the

---
 rtl/dispatch_sequencer.sv | 158 +++++++++++++++
 tb/tb_dispatch_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_sequencer.sv
// Command-driven sequencer for the NxN skewed matrix dispatcher.
// A command loads and streams one or more tiles back to back. Each tile gets
// one mat_load strobe followed by a diagonal wavefront sweep of disp_count.
// When add mode is selected, the FP-adder pipeline is allowed to drain before
// done is pulsed.
module dispatch_sequencer #(
  parameter int N       = 4,
  parameter int CNT_W   = 6,
  parameter int ADD_LAT = 3,
  parameter int TILE_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_add,
  input  logic [TILE_W-1:0] cmd_tiles,
  input  logic              abort,
  output logic              mat_load,
  output logic [CNT_W-1:0]  disp_count,
  output logic              disp_add,
  output logic [N-1:0]      lane_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  // Last wavefront index of a tile; the count never goes beyond this value.
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(2 * N - 2);
  // Drain counter width; it must be able to hold ADD_LAT-1.
  localparam int DRAIN_W = (ADD_LAT > 2) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t             state;
  logic [TILE_W-1:0]  tiles_left;
  logic [DRAIN_W-1:0] drain_cnt;

  // Lane k carries a live element while the wavefront index lies in [k, k+N-1].
  function automatic logic [N-1:0] lane_mask(input logic [CNT_W-1:0] cnt);
    logic [N-1:0] mask;
    mask = '0;
    for (int k = 0; k < N; k++) begin
      mask[k] = (int'(cnt) >= k) && (int'(cnt) <= k + N - 1);
    end
    return mask;
  endfunction

  // Single registered FSM; every output is updated together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tiles_left <= '0;
      drain_cnt  <= '0;
      cmd_ready  <= 1'b1;
      mat_load   <= 1'b0;
      disp_count <= '0;
      disp_add   <= 1'b0;
      lane_valid <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      mat_load <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;

      if (abort && (state != IDLE)) begin
        // Abandon the command; in IDLE the abort input has no effect.
        state      <= IDLE;
        aborted    <= 1'b1;
        cmd_ready  <= 1'b1;
        busy       <= 1'b0;
        disp_count <= '0;
        disp_add   <= 1'b0;
        lane_valid <= '0;
      end else begin
        case (state)
          IDLE: begin
            // An abort in the same cycle suppresses the command.
            if (cmd_valid && !abort) begin
              state      <= LOAD;
              disp_add   <= cmd_add;
              tiles_left <= (cmd_tiles == '0) ? TILE_W'(1) : cmd_tiles;
              cmd_ready  <= 1'b0;
              busy       <= 1'b1;
              mat_load   <= 1'b1;
              disp_count <= '0;
              lane_valid <= '0;
            end
          end

          LOAD: begin
            state      <= STREAM;
            disp_count <= '0;
            lane_valid <= lane_mask('0);
          end

          STREAM: begin
            if (disp_count == LAST_COUNT) begin
              lane_valid <= '0;
              if (tiles_left > TILE_W'(1)) begin
                // Next tile follows immediately, without an idle gap.
                tiles_left <= tiles_left - TILE_W'(1);
                state      <= LOAD;
                mat_load   <= 1'b1;
                disp_count <= '0;
              end else if (disp_add && (ADD_LAT > 0)) begin
                state     <= DRAIN;
                drain_cnt <= DRAIN_W'(ADD_LAT - 1);
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              disp_count <= disp_count + CNT_W'(1);
              lane_valid <= lane_mask(disp_count + CNT_W'(1));
            end
          end

          DRAIN: begin
            // disp_count stays parked at the last index while the adders empty.
            if (drain_cnt == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
          end

          DONE: begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            disp_add   <= 1'b0;
            disp_count <= '0;
          end

          default: begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            disp_add   <= 1'b0;
            disp_count <= '0;
            lane_valid <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dispatch_sequencer.sv
// Scoreboard bench for dispatch_sequencer (N=4, ADD_LAT=3).
// The stimulus pushes the expected output record for every busy or aborted
// cycle, tagged with its cycle number. A monitor pops and compares a record
// whenever the DUT reports busy or aborted.
module tb_dispatch_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_add;
  logic [3:0] cmd_tiles;
  logic       abort;
  logic       mat_load;
  logic [5:0] disp_count;
  logic       disp_add;
  logic [3:0] lane_valid;
  logic       busy;
  logic       done;
  logic       aborted;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic        ml;
    logic [5:0]  cnt;
    logic        chk_cnt;
    logic [3:0]  lane;
    logic        add;
    logic        busy;
    logic        done;
    logic        ab;
    logic        rdy;
  } exp_t;

  exp_t sb[$];

  logic [3:0] lane_tab [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                               4'b1110, 4'b1100, 4'b1000};

  dispatch_sequencer #(
    .N      (4),
    .CNT_W  (6),
    .ADD_LAT(3),
    .TILE_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_add   (cmd_add),
    .cmd_tiles (cmd_tiles),
    .abort     (abort),
    .mat_load  (mat_load),
    .disp_count(disp_count),
    .disp_add  (disp_add),
    .lane_valid(lane_valid),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int c, input logic ml, input int cnt, input logic chk,
                         input logic [3:0] lane, input logic add, input logic dn,
                         input logic ab);
    exp_t e;
    e.cyc     = c;
    e.ml      = ml;
    e.cnt     = 6'(cnt);
    e.chk_cnt = chk;
    e.lane    = lane;
    e.add     = add;
    e.busy    = !ab;
    e.done    = dn;
    e.ab      = ab;
    e.rdy     = ab;
    sb.push_back(e);
  endtask

  // One complete command: LOAD + 7 STREAM cycles per tile, 3 DRAIN cycles in
  // add mode, then DONE. acc is the cycle in which the command is offered.
  task automatic push_run(input int acc, input logic add, input int tiles,
                          output int done_cyc);
    int c;
    int t;
    c = acc + 1;
    t = (tiles == 0) ? 1 : tiles;
    for (int tile = 0; tile < t; tile++) begin
      push_ev(c, 1'b1, 0, 1'b1, 4'b0000, add, 1'b0, 1'b0);
      c++;
      for (int i = 0; i < 7; i++) begin
        push_ev(c, 1'b0, i, 1'b1, lane_tab[i], add, 1'b0, 1'b0);
        c++;
      end
    end
    if (add) begin
      for (int d = 0; d < 3; d++) begin
        push_ev(c, 1'b0, 6, 1'b1, 4'b0000, add, 1'b0, 1'b0);
        c++;
      end
    end
    push_ev(c, 1'b0, 6, 1'b0, 4'b0000, add, 1'b1, 1'b0);
    done_cyc = c;
  endtask

  // Monitor: every busy or aborted cycle must match the next queued record.
  always @(negedge clk) begin
    exp_t e;
    logic [16:0] act_v;
    logic [16:0] exp_v;
    if (rst_n && (busy || aborted)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_output cyc=%0d busy=%b aborted=%b done=%b required no activity",
                 cyc, busy, aborted, done);
      end else begin
        e = sb.pop_front();
        if (cyc != int'(e.cyc)) begin
          failures++;
          $display("[TB] FAIL event_cycle got=%0d expected=%0d", cyc, e.cyc);
        end
        checks++;
        act_v = {mat_load, e.chk_cnt ? disp_count : 6'd0, lane_valid, disp_add,
                 busy, done, aborted, cmd_ready};
        exp_v = {e.ml, e.chk_cnt ? e.cnt : 6'd0, e.lane, e.add,
                 e.busy, e.done, e.ab, e.rdy};
        if (act_v !== exp_v) begin
          failures++;
          $display("[TB] FAIL outputs cyc=%0d got ml=%b cnt=%0d lane=%b add=%b busy=%b done=%b ab=%b rdy=%b expected ml=%b cnt=%0d lane=%b add=%b busy=%b done=%b ab=%b rdy=%b",
                   cyc, act_v[16], act_v[15:10], act_v[9:6], act_v[5], act_v[4], act_v[3],
                   act_v[2], act_v[1], exp_v[16], exp_v[15:10], exp_v[9:6], exp_v[5],
                   exp_v[4], exp_v[3], exp_v[2], exp_v[1]);
        end
      end
    end
  end

  task automatic check_idle(input string name);
    logic [15:0] act_v;
    logic [15:0] exp_v;
    act_v = {cmd_ready, mat_load, disp_count, disp_add, lane_valid, busy, done, aborted};
    exp_v = {1'b1, 1'b0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s got=%b expected=%b", name, act_v, exp_v);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s pending_events=%0d expected=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Offer a command for exactly one cycle; acc is the cycle it is offered in.
  task automatic applyStimulus(input logic add, input logic [3:0] tiles, output int acc);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_add   = add;
    cmd_tiles = tiles;
    acc       = cyc;
  endtask

  task automatic release_cmd();
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_add   = 1'b0;
    cmd_tiles = 4'd0;
  endtask

  initial begin
    int acc;
    int dc;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_add   = 1'b0;
    cmd_tiles = 4'd0;
    abort     = 1'b0;

    repeat (3) @(negedge clk);
    check_idle("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle_after_reset");

    // Single pass-through tile: done 9 cycles after accept.
    $display("[TB] single tile, pass-through");
    applyStimulus(1'b0, 4'd1, acc);
    push_run(acc, 1'b0, 1, dc);
    release_cmd();
    wait_until(dc + 1);
    check_idle("idle_after_single");
    check_drained("single_drained");

    // Two tiles in add mode: done 20 cycles after accept.
    $display("[TB] two tiles, accumulate");
    applyStimulus(1'b1, 4'd2, acc);
    push_run(acc, 1'b1, 2, dc);
    release_cmd();
    wait_until(dc + 1);
    check_idle("idle_after_two_tiles");
    check_drained("two_tiles_drained");

    // Zero tiles behaves as one tile.
    $display("[TB] zero tiles");
    applyStimulus(1'b0, 4'd0, acc);
    push_run(acc, 1'b0, 1, dc);
    release_cmd();
    wait_until(dc + 1);
    check_drained("zero_tiles_drained");

    // Reset pulse in the middle of STREAM.
    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 4'd1, acc);
    push_ev(acc + 1, 1'b1, 0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      push_ev(acc + 2 + i, 1'b0, i, 1'b1, lane_tab[i], 1'b1, 1'b0, 1'b0);
    release_cmd();
    wait_until(acc + 4);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_idle("reset_mid_stream");
    rst_n = 1'b1;
    check_drained("reset_mid_drained");
    applyStimulus(1'b1, 4'd1, acc);
    push_run(acc, 1'b1, 1, dc);
    release_cmd();
    wait_until(dc + 1);
    check_idle("idle_after_reset_run");
    check_drained("after_reset_drained");

    // Abort while disp_count is 3.
    $display("[TB] abort mid-stream");
    applyStimulus(1'b1, 4'd1, acc);
    push_ev(acc + 1, 1'b1, 0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      push_ev(acc + 2 + i, 1'b0, i, 1'b1, lane_tab[i], 1'b1, 1'b0, 1'b0);
    push_ev(acc + 6, 1'b0, 0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    release_cmd();
    wait_until(acc + 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("idle_after_abort");
    check_drained("abort_drained");

    // Abort in IDLE is ignored; abort beats a simultaneous command.
    $display("[TB] abort in idle");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_add   = 1'b1;
    cmd_tiles = 4'd1;
    @(negedge clk);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_idle("idle_abort_ignored");
    check_drained("idle_abort_drained");

    // cmd_valid held high: second command accepted the cycle after done.
    $display("[TB] back-to-back commands");
    applyStimulus(1'b0, 4'd1, acc);
    push_run(acc, 1'b0, 1, dc);
    push_run(dc + 1, 1'b0, 1, dc);
    wait_until(acc + 11);
    cmd_valid = 1'b0;
    wait_until(dc + 1);
    check_idle("idle_after_back_to_back");
    check_drained("back_to_back_drained");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
